// File: rtl/gfx_pattern_writer.sv
// gfx_pattern_writer
//   Pixel-stream source for the gfx framebuffer write port. Emits {x, y, color}
//   writes under a valid/ready handshake in LINEAR, STRIDE, RANDOM or SOLID mode,
//   for a programmed number of frames or continuously until stopped.
//
//   Build option: define GFX_PATTERN_RANDOM_EN to include the RANDOM mode
//   (32-bit Galois LFSR plus SEEK state). Without it, mode 2 runs as LINEAR.
//
// Ports
//   clk_i          system clock
//   reset_n_i      asynchronous active-low reset
//   start_i        1-cycle pulse, latches mode/stride/frames/fill_color in IDLE
//   stop_i         abort; taken at the next handshake, or at once if not valid
//   mode_i         0 LINEAR, 1 STRIDE, 2 RANDOM, 3 SOLID
//   stride_i       x step for STRIDE (0 behaves as 1)
//   frames_i       frames to emit, 0 = run until stop
//   fill_color_i   color used in SOLID
//   gfx_x_o        pixel x
//   gfx_y_o        pixel y
//   gfx_color_o    pixel color
//   gfx_valid_o    payload valid
//   gfx_ready_i    sink accepts payload
//   busy_o         high outside IDLE
//   done_o         1-cycle pulse on completion or abort
//   frame_cnt_o    frames completed since start (wraps at 256)
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | clear position and frame count
// EMIT  | payload valid, advance on handshake
// SEEK  | RANDOM only: step LFSR until an in-range coordinate appears
module gfx_pattern_writer #(
  parameter int          H_VISIBLE  = 640,
  parameter int          V_VISIBLE  = 480,
  parameter int          PIXEL_BITS = 12,
  parameter int          FB_X_BITS  = $clog2(H_VISIBLE),
  parameter int          FB_Y_BITS  = $clog2(V_VISIBLE),
  parameter logic [31:0] LFSR_SEED  = 32'hACE1_1234
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic [1:0]            mode_i,
  input  logic [FB_X_BITS-1:0]  stride_i,
  input  logic [7:0]            frames_i,
  input  logic [PIXEL_BITS-1:0] fill_color_i,
  output logic [FB_X_BITS-1:0]  gfx_x_o,
  output logic [FB_Y_BITS-1:0]  gfx_y_o,
  output logic [PIXEL_BITS-1:0] gfx_color_o,
  output logic                  gfx_valid_o,
  input  logic                  gfx_ready_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [7:0]            frame_cnt_o
);

  if (LFSR_SEED == 32'h0) begin : g_bad_seed
    $error("gfx_pattern_writer: LFSR_SEED must be nonzero");
  end

`ifdef GFX_PATTERN_RANDOM_EN
  if (FB_X_BITS + FB_Y_BITS > 32) begin : g_bad_width
    $error("gfx_pattern_writer: FB_X_BITS + FB_Y_BITS must not exceed 32");
  end

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  localparam int          PIX_W     = $clog2(H_VISIBLE * V_VISIBLE);
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(H_VISIBLE * V_VISIBLE - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_EMIT = 2'd2,
    S_SEEK = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_EMIT = 2'd2
  } state_t;
`endif

  state_t                state_q, state_d;
  logic [1:0]            mode_q, mode_d;
  logic [FB_X_BITS-1:0]  stride_q, stride_d;
  logic [7:0]            frames_q, frames_d;
  logic [PIXEL_BITS-1:0] fill_q, fill_d;
  logic [FB_X_BITS-1:0]  x_q, x_d;
  logic [FB_Y_BITS-1:0]  y_q, y_d;
  logic [7:0]            frame_cnt_q, frame_cnt_d;
  logic                  done_q, done_d;

  logic                  is_stride;
  logic                  is_solid;
  logic [FB_X_BITS-1:0]  stride_eff;
  logic [FB_X_BITS:0]    x_sum;
  logic [FB_X_BITS-1:0]  x_adv;
  logic [FB_Y_BITS-1:0]  y_adv;
  logic                  row_end;
  logic                  frame_end;
  logic                  last_frame;
  logic [PIXEL_BITS-1:0] raster_color;

`ifdef GFX_PATTERN_RANDOM_EN
  logic                  is_random;
  logic [31:0]           lfsr_q, lfsr_d, lfsr_step;
  logic [PIX_W-1:0]      pix_q, pix_d;
  logic [FB_X_BITS-1:0]  cand_x;
  logic [FB_Y_BITS-1:0]  cand_y;
  logic                  cand_ok;

  assign is_random = (mode_q == 2'd2);
  assign lfsr_step = lfsr_q[0] ? ({1'b0, lfsr_q[31:1]} ^ LFSR_TAPS)
                               : {1'b0, lfsr_q[31:1]};
  assign cand_x    = lfsr_q[FB_X_BITS-1:0];
  assign cand_y    = lfsr_q[FB_X_BITS +: FB_Y_BITS];
  assign cand_ok   = ({1'b0, cand_x} < (FB_X_BITS+1)'(H_VISIBLE)) &&
                     ({1'b0, cand_y} < (FB_Y_BITS+1)'(V_VISIBLE));
`endif

  assign is_stride  = (mode_q == 2'd1);
  assign is_solid   = (mode_q == 2'd3);
  assign stride_eff = (stride_q == '0) ? FB_X_BITS'(1) : stride_q;
  // One extra bit so a step past the right edge is seen rather than wrapped.
  assign x_sum      = {1'b0, x_q} + {1'b0, stride_eff};
  assign last_frame = (frames_q != 8'd0) && ((frame_cnt_q + 8'd1) == frames_q);
  assign raster_color = PIXEL_BITS'(PIXEL_BITS'(y_q) * PIXEL_BITS'(H_VISIBLE)
                                    + PIXEL_BITS'(x_q));

  // Position after the current payload is accepted.
  always_comb begin
    x_adv     = x_q;
    y_adv     = y_q;
    row_end   = 1'b0;
    frame_end = 1'b0;
    if (is_stride) begin
      if (x_sum >= (FB_X_BITS+1)'(H_VISIBLE)) row_end = 1'b1;
      else                                   x_adv   = x_sum[FB_X_BITS-1:0];
    end else begin
      if (x_q == FB_X_BITS'(H_VISIBLE - 1)) row_end = 1'b1;
      else                                  x_adv   = x_q + 1'b1;
    end
    if (row_end) begin
      x_adv = '0;
      if (y_q == FB_Y_BITS'(V_VISIBLE - 1)) begin
        y_adv     = '0;
        frame_end = 1'b1;
      end else begin
        y_adv = y_q + 1'b1;
      end
    end
`ifdef GFX_PATTERN_RANDOM_EN
    // Random frames are counted in accepted pixels, not raster position.
    if (is_random) begin
      x_adv     = x_q;
      y_adv     = y_q;
      frame_end = (pix_q == PIX_LAST);
    end
`endif
  end

  // State register and datapath registers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= S_IDLE;
      mode_q      <= 2'd0;
      stride_q    <= '0;
      frames_q    <= 8'd0;
      fill_q      <= '0;
      x_q         <= '0;
      y_q         <= '0;
      frame_cnt_q <= 8'd0;
      done_q      <= 1'b0;
`ifdef GFX_PATTERN_RANDOM_EN
      lfsr_q      <= LFSR_SEED;
      pix_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      stride_q    <= stride_d;
      frames_q    <= frames_d;
      fill_q      <= fill_d;
      x_q         <= x_d;
      y_q         <= y_d;
      frame_cnt_q <= frame_cnt_d;
      done_q      <= done_d;
`ifdef GFX_PATTERN_RANDOM_EN
      lfsr_q      <= lfsr_d;
      pix_q       <= pix_d;
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    stride_d    = stride_q;
    frames_d    = frames_q;
    fill_d      = fill_q;
    x_d         = x_q;
    y_d         = y_q;
    frame_cnt_d = frame_cnt_q;
    done_d      = 1'b0;
`ifdef GFX_PATTERN_RANDOM_EN
    lfsr_d      = lfsr_q;
    pix_d       = pix_q;
`endif
    case (state_q)
      S_IDLE: begin
        // start wins over a coincident stop; stop has nothing to abort here.
        if (start_i) begin
          mode_d   = mode_i;
          stride_d = stride_i;
          frames_d = frames_i;
          fill_d   = fill_color_i;
          state_d  = S_LOAD;
        end
      end
      S_LOAD: begin
        x_d         = '0;
        y_d         = '0;
        frame_cnt_d = 8'd0;
`ifdef GFX_PATTERN_RANDOM_EN
        pix_d       = '0;
`endif
        if (stop_i) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
`ifdef GFX_PATTERN_RANDOM_EN
          state_d = is_random ? S_SEEK : S_EMIT;
`else
          state_d = S_EMIT;
`endif
        end
      end
      S_EMIT: begin
        if (gfx_ready_i) begin
          x_d = x_adv;
          y_d = y_adv;
`ifdef GFX_PATTERN_RANDOM_EN
          if (is_random) pix_d = frame_end ? '0 : pix_q + 1'b1;
`endif
          if (frame_end) frame_cnt_d = frame_cnt_q + 8'd1;
          if (stop_i || (frame_end && last_frame)) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
`ifdef GFX_PATTERN_RANDOM_EN
            state_d = is_random ? S_SEEK : S_EMIT;
`else
            state_d = S_EMIT;
`endif
          end
        end
      end
`ifdef GFX_PATTERN_RANDOM_EN
      S_SEEK: begin
        lfsr_d = lfsr_step;
        if (stop_i) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else if (cand_ok) begin
          x_d     = cand_x;
          y_d     = cand_y;
          state_d = S_EMIT;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs.
  always_comb begin
    gfx_valid_o = (state_q == S_EMIT);
    busy_o      = (state_q != S_IDLE);
    done_o      = done_q;
    gfx_x_o     = x_q;
    gfx_y_o     = y_q;
    gfx_color_o = is_solid ? fill_q : raster_color;
    frame_cnt_o = frame_cnt_q;
  end

endmodule
